inst_loader: RTL and testbench

Boot-time program loader for the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the instruction store through the fetcher's load port (`load`, `load_inst`, address). It holds the CPU in reset until the whole program is written. It sits between the external program source and the fetcher, and owns the instruction store's write side during boot.

---
 rtl/inst_loader_pkg.sv | 19 +
 rtl/inst_loader_word_assembler.sv | 44 ++++
 rtl/inst_loader.sv | 107 ++++++++++
 tb/tb_inst_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared word/address types and the loader's FSM encoding and stream constants.
package Types;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;
endpackage

package LoaderType;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    WORD   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/inst_loader_word_assembler.sv
// Packs big-endian bytes into 32-bit words; word_valid pulses one cycle after the last byte.
module WordAssembler
  import LoaderType::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  // High when the byte being pushed now completes a word.
  assign last = push && (cnt_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= 2'd0;
      shift_q    <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else if (clear) begin
      cnt_q      <= 2'd0;
      shift_q    <= 24'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (push) begin
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {shift_q[15:0], byte_in};
        if (last) begin
          word       <= {shift_q, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a length-prefixed byte stream and writes words into the instruction store.
// Handshake: a byte moves on every rising edge where byte_valid && byte_ready; byte_ready depends only on state.
module inst_loader
  import Types::*;
  import LoaderType::*;
#(
  parameter addr_t BASE_ADDR = 32'h0000_0000,
  parameter int    MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        load,
  output logic [31:0] load_addr,
  output logic [31:0] load_inst,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [2:0]  state_dbg
);

  localparam int LEN_W = 8 * LEN_BYTES;

  loader_state_t    state_q, state_d;
  logic [7:0]       len_hi_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic             xfer, push, clear, word_last;
  logic [31:0]      req_len;

  assign xfer       = byte_valid && byte_ready;
  assign push       = xfer && (state_q == WORD);
  assign req_len    = {{(32 - LEN_W){1'b0}}, len_hi_q, byte_data};
  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == WORD);
  assign cpu_hold   = (state_q != DONE);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign state_dbg  = state_q;

  WordAssembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (push),
    .byte_in    (byte_data),
    .word       (load_inst),
    .word_valid (load),
    .last       (word_last)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_HI;
          clear   = 1'b1;
        end
      end
      LEN_HI: if (xfer) state_d = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (req_len == 32'd0)             state_d = DONE;
          else if (req_len > 32'(MAX_WORDS)) state_d = ERROR;
          else                              state_d = WORD;
        end
      end
      // DONE is entered on the edge that registers the final word, so done and load coincide.
      WORD: if (word_last && (idx_q + LEN_W'(1) == len_q)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      len_hi_q  <= 8'd0;
      len_q     <= '0;
      idx_q     <= '0;
      load_addr <= 32'd0;
    end else begin
      state_q <= state_d;
      if (clear) begin
        len_hi_q <= 8'd0;
        len_q    <= '0;
        idx_q    <= '0;
      end else if (xfer) begin
        case (state_q)
          LEN_HI: len_hi_q <= byte_data;
          LEN_LO: len_q    <= {len_hi_q, byte_data};
          WORD: begin
            if (word_last) begin
              load_addr <= BASE_ADDR + {{(30 - LEN_W){1'b0}}, idx_q, 2'b00};
              idx_q     <= idx_q + LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: two instances (base 0 and base 0x0040_0000) share one stimulus stream.
module tb_inst_loader;
  localparam logic [31:0] BASE1 = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;

  logic        br0, load0, hold0, done0, err0;
  logic [31:0] addr0, inst0;
  logic [2:0]  st0;
  logic        br1, load1, hold1, done1, err1;
  logic [31:0] addr1, inst1;
  logic [2:0]  st1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_cyc[$];
  logic [64:0] exp_q[$];   // {last, addr offset, inst}
  bit gap = 1'b0;

  inst_loader dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br0), .load(load0), .load_addr(addr0), .load_inst(inst0),
    .cpu_hold(hold0), .done(done0), .error(err0), .state_dbg(st0)
  );

  inst_loader #(.BASE_ADDR(BASE1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(br1), .load(load1), .load_addr(addr1), .load_inst(inst1),
    .cpu_hold(hold1), .done(done1), .error(err1), .state_dbg(st1)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every load pulse pops one expected word.
  always @(negedge clk) begin : mon
    logic [64:0] e;
    if (rst && (load0 || load1)) begin
      load_cyc.push_back(cyc);
      chk("load_pair", load1, load0);
      chk("exp_q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("inst0", inst0, e[31:0]);
        chk("addr0", addr0, e[63:32]);
        chk("inst1", inst1, e[31:0]);
        chk("addr1", addr1, e[63:32] + BASE1);
        chk("done_at_load", done0, e[64]);
        chk("hold_at_load", hold0, !e[64]);
      end
    end
  end

  // Driver tasks (all return #1 after a rising edge)
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!br0 && n < 20) begin cycles(1); n++; end
    if (!br0) chk("byte_ready_timeout", br0, 1);
    else cycles(1);
    byte_valid = 1'b0;
    if (gap) cycles(1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] off, input logic last);
    exp_q.push_back({last, off, w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic check_reset();
    chk("rst_ready", br0, 0);
    chk("rst_load", load0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_inst", inst0, 0);
    chk("rst_hold", hold0, 1);
    chk("rst_done", done0, 0);
    chk("rst_error", err0, 0);
    chk("rst_state", st0, 0);
    chk("rst_addr1", addr1, 0);
  endtask

  initial begin
    rst = 1'b0;
    cycles(2);
    check_reset();
    rst = 1'b1;
    cycles(1);
    chk("idle_ready", br0, 0);

    // Two-word program
    do_start();
    chk("state_len_hi", st0, 1);
    chk("len_hi_ready", br0, 1);
    load_cyc.delete();
    send_byte(8'h00);
    send_byte(8'h02);
    chk("state_word", st0, 3);
    send_word(32'h2008_0005, 32'd0, 1'b0);
    chk("hold_mid", hold0, 1);
    send_word(32'h0000_0000, 32'd4, 1'b1);
    chk("done_last", done0, 1);
    chk("hold_last", hold0, 0);
    cycles(1);
    chk("load_deassert", load0, 0);
    chk("addr_hold", addr0, 32'd4);
    chk("ready_in_done", br0, 0);
    chk("b2b_loads", load_cyc.size(), 2);
    if (load_cyc.size() == 2) chk("b2b_spacing", load_cyc[1] - load_cyc[0], 4);

    // Empty program
    do_start();
    chk("hold_restart", hold0, 1);
    load_cyc.delete();
    send_byte(8'h00);
    chk("empty_not_early", done0, 0);
    send_byte(8'h00);
    chk("empty_done", done0, 1);
    chk("empty_hold", hold0, 0);
    cycles(2);
    chk("empty_no_load", load_cyc.size(), 0);

    // Length too large
    do_start();
    send_byte(8'h04);
    send_byte(8'h01);
    chk("big_error", err0, 1);
    chk("big_ready", br0, 0);
    chk("big_hold", hold0, 1);
    chk("big_done", done0, 0);
    chk("big_state", st0, 5);
    do_start();
    chk("err_restart_state", st0, 1);
    chk("err_restart_error", err0, 0);

    // Source gaps (already in LEN_HI)
    load_cyc.delete();
    gap = 1'b1;
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(32'h2008_0005, 32'd0, 1'b0);
    send_word(32'h0000_0000, 32'd4, 1'b1);
    gap = 1'b0;
    cycles(1);
    chk("gap_loads", load_cyc.size(), 2);
    if (load_cyc.size() == 2) chk("gap_spacing", load_cyc[1] - load_cyc[0], 8);
    chk("gap_done", done0, 1);

    // Reset mid-word
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h08);
    rst = 1'b0;
    cycles(1);
    check_reset();
    rst = 1'b1;
    cycles(1);
    chk("post_rst_no_load", load0, 0);
    chk("post_rst_idle", st0, 0);
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hDEAD_BEEF, 32'd0, 1'b1);
    cycles(1);

    // Reload after DONE
    chk("reload_pre_hold", hold0, 0);
    chk("reload_pre_done", done0, 1);
    do_start();
    chk("reload_hold0", hold0, 1);
    chk("reload_hold1", hold1, 1);
    chk("reload_done", done0, 0);
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'h1234_5678, 32'd0, 1'b1);
    chk("reload_base_addr1", addr1, 32'h0040_0000);
    cycles(1);
    chk("reload_done_end", done1, 1);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
